// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - widths, latency and arithmetic mode for cim_mac_tree_acc; CIM_SIGNED_EN selects signed weights
package cim_pkg;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Product width of one activation times one weight
  function automatic int prod_w(input int in_w, input int w_w);
    return in_w + w_w;
  endfunction

  // Width of a partial sum after the given number of tree levels
  function automatic int sum_w(input int in_w, input int w_w, input int level);
    return in_w + w_w + level;
  endfunction

  // Result width: tree output plus headroom for MAX_TILES accumulations
  function automatic int out_w(input int in_w, input int w_w, input int n_ch, input int max_tiles);
    return in_w + w_w + clog2(n_ch) + clog2(max_tiles);
  endfunction

  // in_valid&in_last edge to out_valid edge
  function automatic int lat(input int n_ch);
    return clog2(n_ch) + 2;
  endfunction

  localparam int PROD_W_DEF = prod_w(4, 4);
  localparam int OUT_W_DEF  = out_w(4, 4, 32, 16);
  localparam int LAT_DEF    = lat(32);

`ifdef CIM_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

endpackage

// File: rtl/cim_tree_level.sv
// rtl/cim_tree_level.sv - one registered pairwise-add level of the reduction tree with valid/last/first/ovf tags
module cim_tree_level
  import cim_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = 8,
  parameter bit SGN  = SIGNED_EN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic                        in_first,
  input  logic                        in_ovf,
  input  logic [N_IN*W-1:0]           in_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic                        out_first,
  output logic                        out_ovf,
  output logic [(N_IN/2)*(W+1)-1:0]   out_data
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*(W+1)-1:0] sums;

  // Each pair is widened by one bit (sign or zero) so no sum is truncated
  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic [W-1:0] a;
    logic [W-1:0] b;
    assign a = in_data[(2*j)*W +: W];
    assign b = in_data[(2*j+1)*W +: W];
    assign sums[j*(W+1) +: W+1] = {SGN & a[W-1], a} + {SGN & b[W-1], b};
  end

  // Register the level; a clear drops the in-flight vector but leaves data alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_first <= 1'b0;
      out_ovf   <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid & ~clr;
      out_last  <= in_last;
      out_first <= in_first;
      out_ovf   <= in_ovf;
      out_data  <= sums;
    end
  end

endmodule

// File: rtl/cim_mac_tree_acc.sv
// rtl/cim_mac_tree_acc.sv - pipelined CIM MAC: weight RAM, product stage, adder tree, tile accumulator; CIM_SIGNED_EN via cim_pkg
module cim_mac_tree_acc
  import cim_pkg::*;
#(
  parameter int N_CH      = 32,
  parameter int IN_W      = 4,
  parameter int W_W       = 4,
  parameter int MAX_TILES = 16,
  parameter int OUT_W     = out_w(IN_W, W_W, N_CH, MAX_TILES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [N_CH*IN_W-1:0]       in_data,
  input  logic                       acc_clr,
  input  logic                       w_we,
  input  logic [clog2(N_CH)-1:0]     w_addr,
  input  logic [W_W-1:0]             w_data,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [clog2(MAX_TILES):0]  out_tiles,
  output logic                       out_ovf
);

  localparam int LVLS = clog2(N_CH);
  localparam int PW   = prod_w(IN_W, W_W);
  localparam int SW   = sum_w(IN_W, W_W, LVLS);
  localparam int CW   = clog2(MAX_TILES) + 1;

  logic [W_W-1:0]     weights [N_CH];
  logic [CW-1:0]      in_cnt;
  logic               accept;
  logic               at_limit;
  logic [N_CH*PW-1:0] prod;
  logic [N_CH*PW-1:0] m_data;
  logic               m_valid, m_last, m_first, m_ovf;

  assign accept   = in_valid & ~acc_clr;
  assign at_limit = (in_cnt == CW'(MAX_TILES - 1));

  // Weight RAM; a vector in the same cycle still sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) weights[k] <= '0;
    end else if (w_we) begin
      weights[w_addr] <= w_data;
    end
  end

  // Input-side tile count decides first/closing tags before the vector enters the pipe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
    end else if (acc_clr) begin
      in_cnt <= '0;
    end else if (in_valid) begin
      in_cnt <= (in_last | at_limit) ? '0 : in_cnt + CW'(1);
    end
  end

  // Products at PW bits: weight sign-extended in signed mode, low bits of the product are exact
  for (genvar k = 0; k < N_CH; k++) begin : g_mul
    logic [PW-1:0] a_ext;
    logic [PW-1:0] w_ext;
    assign a_ext = PW'(in_data[k*IN_W +: IN_W]);
    assign w_ext = {{IN_W{SIGNED_EN & weights[k][W_W-1]}}, weights[k]};
    assign prod[k*PW +: PW] = a_ext * w_ext;
  end

  // Stage M: register products and tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_first <= 1'b0;
      m_ovf   <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= accept;
      m_last  <= in_last | at_limit;
      m_first <= (in_cnt == '0);
      m_ovf   <= at_limit & ~in_last;
      m_data  <= prod;
    end
  end

  for (genvar i = 0; i < LVLS; i++) begin : g_lvl
    localparam int NI = N_CH >> i;
    localparam int WI = PW + i;
    logic [NI*WI-1:0]         d_in;
    logic                     v_in, l_in, f_in, o_in;
    logic [(NI/2)*(WI+1)-1:0] d_out;
    logic                     v_out, l_out, f_out, o_out;
    if (i == 0) begin : g_src
      assign d_in = m_data;
      assign v_in = m_valid;
      assign l_in = m_last;
      assign f_in = m_first;
      assign o_in = m_ovf;
    end else begin : g_src
      assign d_in = g_lvl[i-1].d_out;
      assign v_in = g_lvl[i-1].v_out;
      assign l_in = g_lvl[i-1].l_out;
      assign f_in = g_lvl[i-1].f_out;
      assign o_in = g_lvl[i-1].o_out;
    end
    cim_tree_level #(.N_IN(NI), .W(WI), .SGN(SIGNED_EN)) u_level (
      .clk(clk), .rst(rst), .clr(acc_clr),
      .in_valid(v_in), .in_last(l_in), .in_first(f_in), .in_ovf(o_in), .in_data(d_in),
      .out_valid(v_out), .out_last(l_out), .out_first(f_out), .out_ovf(o_out), .out_data(d_out)
    );
  end

  logic [SW-1:0]    t_sum;
  logic             t_valid, t_last, t_first, t_ovf;
  logic [OUT_W-1:0] sum_ext, acc, acc_next;
  logic [CW-1:0]    acc_cnt, cnt_next;
  logic             a_close, a_ovf;

  assign t_sum    = g_lvl[LVLS-1].d_out;
  assign t_valid  = g_lvl[LVLS-1].v_out;
  assign t_last   = g_lvl[LVLS-1].l_out;
  assign t_first  = g_lvl[LVLS-1].f_out;
  assign t_ovf    = g_lvl[LVLS-1].o_out;
  assign sum_ext  = {{(OUT_W-SW){SIGNED_EN & t_sum[SW-1]}}, t_sum};
  assign acc_next = t_first ? sum_ext : acc + sum_ext;
  assign cnt_next = t_first ? CW'(1) : acc_cnt + CW'(1);

  // Stage A: load on first-tagged sums, add otherwise; remember whether this sum closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      acc_cnt <= '0;
      a_close <= 1'b0;
      a_ovf   <= 1'b0;
    end else if (acc_clr) begin
      acc     <= '0;
      acc_cnt <= '0;
      a_close <= 1'b0;
      a_ovf   <= 1'b0;
    end else begin
      a_close <= t_valid & t_last;
      a_ovf   <= t_valid & t_ovf;
      if (t_valid) begin
        acc     <= acc_next;
        acc_cnt <= cnt_next;
      end
    end
  end

  // Output register: pulse on closure, hold data otherwise; a clear kills the pending pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tiles <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= a_close & ~acc_clr;
      if (a_close & ~acc_clr) begin
        out_data  <= acc;
        out_tiles <= acc_cnt;
        out_ovf   <= a_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cim_mac_tree_acc.sv
// tb/tb_cim_mac_tree_acc.sv - self-checking bench for cim_mac_tree_acc with a dot-product scoreboard model
module tb_cim_mac_tree_acc;

  localparam int N_CH = 32;
  localparam int MAXT = 16;
  localparam int LATC = 7;

  typedef struct {
    int          cyc;
    logic [16:0] data;
    logic [4:0]  tiles;
    logic        ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, acc_clr, w_we;
  logic [127:0] in_data;
  logic [4:0]   w_addr;
  logic [3:0]   w_data;
  logic         out_valid, out_ovf;
  logic [16:0]  out_data;
  logic [4:0]   out_tiles;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  res_t        exp_q[$];
  res_t        pulses[$];
  logic [16:0] hold = '0;
  logic [3:0]  mw [N_CH];
  longint      m_acc = 0;
  int          m_cnt = 0;

  cim_mac_tree_acc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .acc_clr(acc_clr), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_data(out_data), .out_tiles(out_tiles), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic int wval(input logic [3:0] w);
`ifdef CIM_SIGNED_EN
    return int'($signed(w));
`else
    return int'(w);
`endif
  endfunction

  function automatic logic [16:0] o17(input longint v);
    return v[16:0];
  endfunction

  function automatic res_t get_pulse(input int i);
    res_t r;
    r = '{-1, 'x, 'x, 1'bx};
    if (i < pulses.size()) r = pulses[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      chk("out_valid_pulse", 64'(out_valid), 64'd1);
      chk("out_data", 64'(out_data), 64'(exp_q[0].data));
      chk("out_tiles", 64'(out_tiles), 64'(exp_q[0].tiles));
      chk("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
      hold = exp_q[0].data;
      void'(exp_q.pop_front());
    end else begin
      chk("out_valid_idle", 64'(out_valid), 64'd0);
      chk("out_data_hold", 64'(out_data), 64'(hold));
    end
    if (out_valid === 1'b1) pulses.push_back('{cyc, out_data, out_tiles, out_ovf});
  endtask

  // Reference: dot product with the weights as they stood before this cycle's write
  task automatic model(input int s);
    if (acc_clr) begin
      while (exp_q.size() > 0 && exp_q[$].cyc >= s) void'(exp_q.pop_back());
      m_acc = 0;
      m_cnt = 0;
    end else if (in_valid) begin
      longint dot;
      dot = 0;
      for (int k = 0; k < N_CH; k++) begin
        int a;
        a = int'(in_data[k*4 +: 4]);
        dot += longint'(a * wval(mw[k]));
      end
      m_acc = (m_cnt == 0) ? dot : m_acc + dot;
      m_cnt++;
      if (in_last || m_cnt == MAXT) begin
        exp_q.push_back('{s + LATC, o17(m_acc), 5'(m_cnt), !in_last});
        m_cnt = 0;
      end
    end
    if (w_we) mw[w_addr] = w_data;
  endtask

  task automatic drive(input bit v, input bit l, input logic [127:0] d, input bit c,
                       input bit we, input logic [4:0] a, input logic [3:0] wd);
    in_valid = v; in_last = l; in_data = d; acc_clr = c;
    w_we = we; w_addr = a; w_data = wd;
    model(cyc + 1);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, '0, '0);
  endtask

  logic [127:0] all15, ones, rd;
  int           n0, s0, wv;
  bit           rv, rl, rc, rwe;

  initial begin
    all15 = '1;
    for (int k = 0; k < N_CH; k++) ones[k*4 +: 4] = 4'd1;
    for (int k = 0; k < N_CH; k++) mw[k] = '0;
    rst = 1'b1; in_valid = 0; in_last = 0; in_data = '0; acc_clr = 0; w_we = 0; w_addr = '0; w_data = '0;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tiles", 64'(out_tiles), 64'd0);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;
    idle(2);

    // All weights 15, single vector of 15s
    for (int k = 0; k < N_CH; k++) drive(0, 0, '0, 0, 1, 5'(k), 4'hF);
    wv = wval(4'hF);
    n0 = pulses.size();
    s0 = cyc + 1;
    drive(1, 1, all15, 0, 0, '0, '0);
    idle(9);
    chk("single_latency", 64'(get_pulse(n0).cyc), 64'(s0 + LATC));
    chk("single_data", 64'(get_pulse(n0).data), 64'(o17(32 * 15 * wv)));
    chk("single_tiles", 64'(get_pulse(n0).tiles), 64'd1);

    // Two-vector accumulation then back-to-back single
    n0 = pulses.size();
    drive(1, 0, all15, 0, 0, '0, '0);
    drive(1, 1, all15, 0, 0, '0, '0);
    drive(1, 1, all15, 0, 0, '0, '0);
    idle(9);
    chk("two_data", 64'(get_pulse(n0).data), 64'(o17(2 * 32 * 15 * wv)));
    chk("two_tiles", 64'(get_pulse(n0).tiles), 64'd2);
    chk("b2b_data", 64'(get_pulse(n0 + 1).data), 64'(o17(32 * 15 * wv)));
    chk("b2b_gap", 64'(get_pulse(n0 + 1).cyc - get_pulse(n0).cyc), 64'd1);

    // Tile limit: 16 vectors without last, then a fresh single
    n0 = pulses.size();
    for (int i = 0; i < MAXT; i++) drive(1, 0, all15, 0, 0, '0, '0);
    drive(1, 1, all15, 0, 0, '0, '0);
    idle(9);
    chk("limit_data", 64'(get_pulse(n0).data), 64'(o17(16 * 32 * 15 * wv)));
    chk("limit_tiles", 64'(get_pulse(n0).tiles), 64'd16);
    chk("limit_ovf", 64'(get_pulse(n0).ovf), 64'd1);
    chk("after_limit_data", 64'(get_pulse(n0 + 1).data), 64'(o17(32 * 15 * wv)));
    chk("after_limit_ovf", 64'(get_pulse(n0 + 1).ovf), 64'd0);

    // Weights k mod 16, write during a vector uses the old weight
    for (int k = 0; k < N_CH; k++) drive(0, 0, '0, 0, 1, 5'(k), 4'(k % 16));
    n0 = pulses.size();
    drive(1, 1, ones, 0, 1, 5'd0, 4'd5);
    drive(1, 1, ones, 0, 0, '0, '0);
    idle(9);
`ifndef CIM_SIGNED_EN
    chk("wr_old_weight", 64'(get_pulse(n0).data), 64'd240);
    chk("wr_new_weight", 64'(get_pulse(n0 + 1).data), 64'd245);
`endif

    // Clear with three vectors in flight
    n0 = pulses.size();
    drive(1, 0, ones, 0, 0, '0, '0);
    drive(1, 0, ones, 0, 0, '0, '0);
    drive(1, 1, ones, 0, 0, '0, '0);
    drive(1, 1, ones, 1, 0, '0, '0);
    idle(10);
    chk("clr_no_pulse", 64'(pulses.size()), 64'(n0));
    drive(1, 1, ones, 0, 0, '0, '0);
    idle(9);
`ifndef CIM_SIGNED_EN
    chk("after_clr_data", 64'(get_pulse(n0).data), 64'd245);
`endif
    chk("after_clr_tiles", 64'(get_pulse(n0).tiles), 64'd1);

`ifdef CIM_SIGNED_EN
    for (int k = 0; k < N_CH; k++) drive(0, 0, '0, 0, 1, 5'(k), 4'hF);
    n0 = pulses.size();
    drive(1, 1, ones, 0, 0, '0, '0);
    idle(9);
    chk("signed_neg32", 64'(get_pulse(n0).data), 64'(o17(-32)));
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd  = {$urandom, $urandom, $urandom, $urandom};
      rv  = ($urandom_range(0, 9) < 7);
      rl  = ($urandom_range(0, 9) < 1);
      rc  = ($urandom_range(0, 49) == 0);
      rwe = ($urandom_range(0, 4) == 0);
      drive(rv, rl, rd, rc, rwe, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    end
    idle(9);

    // Asynchronous reset mid-stream
    drive(1, 0, all15, 0, 0, '0, '0);
    drive(1, 1, all15, 0, 0, '0, '0);
    drive(1, 0, all15, 0, 0, '0, '0);
    in_valid = 0; in_last = 0; w_we = 0; acc_clr = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_tiles", 64'(out_tiles), 64'd0);
    chk("arst_ovf", 64'(out_ovf), 64'd0);
    exp_q.delete();
    for (int k = 0; k < N_CH; k++) mw[k] = '0;
    m_acc = 0; m_cnt = 0; hold = '0;
    tick();
    rst = 1'b0;
    n0 = pulses.size();
    drive(1, 1, all15, 0, 0, '0, '0);
    idle(9);
    chk("arst_weights_zero", 64'(get_pulse(n0).data), 64'd0);
    chk("arst_tiles_one", 64'(get_pulse(n0).tiles), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
